// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the data-memory access sequencer.
// Sizes follow the decoder's SizeSrc encoding; 2'b11 behaves as a word.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } seq_state_t;

  function automatic logic [3:0] byte_enable(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b1111;
    if (size == SIZE_BYTE) be = 4'b0001 << a;
    if (size == SIZE_HALF) be = 4'b0011 << a;
    return be;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic m;
    m = (a != 2'b00);
    if (size == SIZE_BYTE) m = 1'b0;
    if (size == SIZE_HALF) m = a[0];
    return m;
  endfunction

  function automatic logic [31:0] store_lanes(
    input logic [1:0]  size,
    input logic [31:0] wdata
  );
    logic [31:0] d;
    d = wdata;
    if (size == SIZE_BYTE) d = {4{wdata[7:0]}};
    if (size == SIZE_HALF) d = {2{wdata[15:0]}};
    return d;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Right-aligns the addressed lane of a bus word and sign/zero extends it.
// Purely combinational so the future cache can share it.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] bus_rdata_i,
  input  logic [1:0]  a_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] rdata_o
);

  logic [31:0] s;

  assign s = bus_rdata_i >> {a_i, 3'b000};

  always_comb begin
    rdata_o = s;
    unique case (1'b1)
      (size_i == SIZE_BYTE):
        rdata_o = {{24{sign_i & s[7]}}, s[7:0]};
      (size_i == SIZE_HALF):
        rdata_o = {{16{sign_i & s[15]}}, s[15:0]};
      default:
        rdata_o = s;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// MEM-stage sequencer: runs one req/ack bus transaction per load/store,
// stalling the pipeline until it completes, times out or is rejected.
module mem_access_sequencer
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              misaligned,
  output logic              bus_error,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_t        state_q, state_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [1:0]        a_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CW-1:0]     cnt_q;

  logic              mis;
  logic              accept;
  logic              tmo;
  logic [DATA_W-1:0] rdata_next;

  assign mis    = mem_access_pkg::misaligned(req_size, req_addr[1:0]);
  assign accept = (state_q == IDLE) & req_valid & ~mis;
  assign tmo    = (state_q == BUSY) & ~bus_ack
                & (cnt_q == CW'(TIMEOUT - 1));

  mem_load_align u_align (
    .bus_rdata_i (bus_rdata),
    .a_i         (a_q),
    .size_i      (size_q),
    .sign_i      (sign_q),
    .rdata_o     (rdata_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (bus_ack || tmo) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    misaligned  = 1'b0;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    rdata_valid = 1'b0;
    bus_error   = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall      = accept;
        misaligned = req_valid & mis;
      end
      BUSY: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        bus_we  = we_q;
      end
      DONE: begin
        rdata_valid = ~we_q & ~err_q;
        bus_error   = err_q;
      end
      default: ;
    endcase
  end

  // Request fields are captured once so the bus stays stable while BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      a_q     <= 2'b00;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_write;
        size_q  <= req_size;
        sign_q  <= req_sign;
        a_q     <= req_addr[1:0];
        addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
        be_q    <= byte_enable(req_size, req_addr[1:0]);
        wdata_q <= store_lanes(req_size, req_wdata);
        err_q   <= 1'b0;
      end
      if (state_q == BUSY) begin
        if (bus_ack) begin
          cnt_q <= '0;
          if (!we_q) rdata_q <= rdata_next;
        end else if (tmo) begin
          cnt_q   <= '0;
          err_q   <= 1'b1;
          rdata_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign rdata     = rdata_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a transaction-level
// reference model checked every cycle plus hand-computed literals.
module tb_mem_access_sequencer;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'hDEADBEEF;

  logic        stall, rdata_valid, misaligned, bus_error;
  logic        bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  mem_access_sequencer #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_sign(req_sign),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .misaligned(misaligned),
    .bus_error(bus_error), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b10) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w,
                                         input int a, input int n,
                                         input bit sgn);
    logic [31:0] v;
    v = w >> (8 * a);
    if (n == 4) return v;
    v = v & ((32'd1 << (8 * n)) - 32'd1);
    if (sgn && v >= (32'd1 << (8 * n - 1)))
      v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // Reference model: phase 0 idle, 1 on the bus, 2 completion cycle
  int          m_phase = 0;
  int          m_nbusy = 0;
  bit          m_we = 0, m_sign = 0, m_err = 0;
  int          m_n = 4, m_a = 0;
  logic [31:0] m_addr = 0, m_wd = 0, m_rdata = 0;
  logic [3:0]  m_be = 0;

  always @(negedge clk) begin
    int  n, a;
    bit  mis_c, ok;
    n     = nbytes(req_size);
    a     = int'(req_addr[1:0]);
    mis_c = (a % n) != 0;
    ok    = (m_phase == 0) && req_valid && !mis_c;
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(ok || m_phase == 1));
      chk("misaligned", 32'(misaligned),
          32'(m_phase == 0 && req_valid && mis_c));
      chk("bus_req", 32'(bus_req), 32'(m_phase == 1));
      chk("bus_we", 32'(bus_we), 32'(m_phase == 1 && m_we));
      chk("rdata_valid", 32'(rdata_valid),
          32'(m_phase == 2 && !m_we && !m_err));
      chk("bus_error", 32'(bus_error), 32'(m_phase == 2 && m_err));
      chk("rdata", rdata, m_rdata);
      if (m_phase == 1) begin
        chk("bus_addr", bus_addr, m_addr);
        chk("bus_be", 32'(bus_be), 32'(m_be));
        chk("bus_wdata", bus_wdata, m_wd);
      end
    end
    if (rst) begin
      m_phase = 0; m_nbusy = 0; m_rdata = 0; m_err = 0;
    end else if (m_phase == 0) begin
      if (ok) begin
        m_phase = 1; m_nbusy = 0; m_err = 0;
        m_we = req_write; m_sign = req_sign;
        m_n = n; m_a = a;
        m_addr = req_addr - 32'(a);
        m_be = 4'(((1 << n) - 1) << a);
        if (n == 1)      m_wd = 32'(req_wdata[7:0]) * 32'h01010101;
        else if (n == 2) m_wd = 32'(req_wdata[15:0]) * 32'h00010001;
        else             m_wd = req_wdata;
      end
    end else if (m_phase == 1) begin
      if (bus_ack) begin
        if (!m_we) m_rdata = m_load(bus_rdata, m_a, m_n, m_sign);
        m_phase = 2;
      end else if (m_nbusy + 1 == TMO) begin
        m_err = 1; m_rdata = 0; m_phase = 2;
      end else begin
        m_nbusy++;
      end
    end else begin
      m_phase = 0;
    end
  end

  logic        sn_stall, sn_req, sn_we, sn_rv, sn_mis, sn_err;
  logic [31:0] sn_addr, sn_wd, sn_rd;
  logic [3:0]  sn_be;
  int          n_stall, n_req, n_rv;

  task automatic clr();
    n_stall = 0; n_req = 0; n_rv = 0;
  endtask

  // Observe one cycle at the falling edge, then advance past the next rising edge
  task automatic cyc();
    @(negedge clk);
    sn_stall = stall;   sn_req = bus_req; sn_we = bus_we;
    sn_rv = rdata_valid; sn_mis = misaligned; sn_err = bus_error;
    sn_addr = bus_addr; sn_wd = bus_wdata; sn_rd = rdata;
    sn_be = bus_be;
    n_stall += int'(stall);
    n_req   += int'(bus_req);
    n_rv    += int'(rdata_valid);
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit w, input logic [1:0] sz,
                       input bit sg, input logic [31:0] ad,
                       input logic [31:0] wd);
    req_valid = 1; req_write = w; req_size = sz;
    req_sign = sg; req_addr = ad; req_wdata = wd;
  endtask

  initial begin
    clr();
    rst = 1;
    repeat (2) cyc();
    chk("rst_stall", 32'(sn_stall), 0);
    chk("rst_bus_req", 32'(sn_req), 0);
    chk("rst_rdata", sn_rd, 0);
    chk("rst_be", 32'(sn_be), 0);
    rst = 0;
    chk_en = 1;
    cyc();

    // LB 0x103 signed, ack in first BUSY cycle
    clr();
    issue(0, 2'b10, 1, 32'h103, 32'h0);
    cyc();
    chk("lb_stall_req_cycle", 32'(sn_stall), 1);
    bus_ack = 1; bus_rdata = 32'h80FF1234;
    cyc();
    chk("lb_bus_addr", sn_addr, 32'h100);
    chk("lb_be", 32'(sn_be), 32'b1000);
    bus_ack = 0; bus_rdata = 32'hDEADBEEF;
    cyc();
    chk("lb_rdata_valid", 32'(sn_rv), 1);
    chk("lb_rdata", sn_rd, 32'hFFFFFF80);
    chk("lb_stall_cycles", n_stall, 2);
    req_valid = 0;
    cyc();

    // LHU 0x102, ack in third BUSY cycle
    clr();
    issue(0, 2'b01, 0, 32'h102, 32'h0);
    cyc();
    cyc();
    chk("lhu_bus_addr", sn_addr, 32'h100);
    chk("lhu_be", 32'(sn_be), 32'b1100);
    cyc();
    bus_ack = 1; bus_rdata = 32'hBEEF0000;
    cyc();
    bus_ack = 0; bus_rdata = 32'hDEADBEEF;
    cyc();
    chk("lhu_rdata", sn_rd, 32'h0000BEEF);
    chk("lhu_stall_cycles", n_stall, 4);
    chk("lhu_req_cycles", n_req, 3);
    req_valid = 0;
    cyc();

    // SB 0x201
    clr();
    issue(1, 2'b10, 0, 32'h201, 32'h123456AB);
    cyc();
    bus_ack = 1;
    cyc();
    chk("sb_we", 32'(sn_we), 1);
    chk("sb_be", 32'(sn_be), 32'b0010);
    chk("sb_wdata", sn_wd, 32'hABABABAB);
    bus_ack = 0;
    cyc();
    chk("sb_done_stall", 32'(sn_stall), 0);
    chk("sb_rdata_held", sn_rd, 32'h0000BEEF);
    chk("sb_no_rdata_valid", n_rv, 0);
    req_valid = 0;
    cyc();

    // LW 0x102 is rejected
    clr();
    issue(0, 2'b00, 0, 32'h102, 32'h0);
    cyc();
    chk("lw_mis_pulse", 32'(sn_mis), 1);
    chk("lw_mis_stall", 32'(sn_stall), 0);
    req_valid = 0;
    cyc();
    cyc();
    chk("lw_mis_no_req", n_req, 0);

    // LW with no ack times out
    clr();
    issue(0, 2'b00, 0, 32'h300, 32'h0);
    cyc();
    repeat (TMO) cyc();
    cyc();
    chk("tmo_bus_error", 32'(sn_err), 1);
    chk("tmo_rdata", sn_rd, 0);
    chk("tmo_req_cycles", n_req, TMO);
    req_valid = 0; bus_ack = 1; bus_rdata = 32'h11111111;
    cyc();
    chk("late_ack_no_req", 32'(sn_req), 0);
    bus_ack = 0;
    cyc();
    chk("late_ack_no_valid", n_rv, 0);

    // LW 0x104 loads a nonzero value before the reset test
    clr();
    issue(0, 2'b11, 0, 32'h104, 32'h0);
    cyc();
    bus_ack = 1; bus_rdata = 32'hCAFEF00D;
    cyc();
    bus_ack = 0; bus_rdata = 32'hDEADBEEF;
    cyc();
    chk("lw_rdata", sn_rd, 32'hCAFEF00D);
    req_valid = 0;
    cyc();

    // Reset in the second BUSY cycle, ack one cycle later
    clr();
    issue(0, 2'b00, 0, 32'h400, 32'h0);
    cyc();
    cyc();
    rst = 1;
    cyc();
    rst = 0; req_valid = 0; bus_ack = 1;
    cyc();
    chk("rst_busy_no_req", 32'(sn_req), 0);
    chk("rst_busy_stall", 32'(sn_stall), 0);
    chk("rst_busy_rdata", sn_rd, 0);
    bus_ack = 0;
    cyc();
    chk("rst_busy_addr", sn_addr, 0);
    chk("rst_busy_no_valid", n_rv, 0);
    chk("rst_busy_req_cycles", n_req, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
